// File: rtl/mem_arbiter.sv
// Shares the memory controller's single core-side port between instruction fetch
// and load/store, one latched transaction at a time, with a BUSY-cycle timeout.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic [63:0] if_rdata,
  output logic        if_ack,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  output logic [63:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  output logic [1:0]  mem_size,
  output logic        mem_unsigned,
  input  logic [63:0] mem_rdata,
  input  logic        mem_done,
  output logic        busy
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state, state_nx;
  logic          last_d;   // 1 when data port was granted last
  logic          grant_d;
  logic          we_q;
  logic          err_q;
  logic [63:0]   rdata_q;
  logic [CW-1:0] cnt;
  logic          pick_d;
  logic          timed_out;

  // Tie goes to whichever port was not served last.
  assign pick_d    = d_req & (~if_req | ~last_d);
  assign timed_out = (cnt == LAST);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (if_req | d_req) state_nx = BUSY;
      BUSY:    if (mem_done | timed_out) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_d       <= 1'b0;
      grant_d      <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      cnt          <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_size     <= '0;
      mem_unsigned <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (if_req | d_req) begin
            grant_d <= pick_d;
            cnt     <= '0;
            if (pick_d) begin
              mem_addr     <= d_addr;
              mem_wdata    <= d_wdata;
              we_q         <= d_we;
              mem_size     <= d_size;
              mem_unsigned <= d_unsigned;
            end else begin
              mem_addr     <= if_addr;
              mem_wdata    <= '0;
              we_q         <= 1'b0;
              mem_size     <= 2'b11;
              mem_unsigned <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (mem_done) begin
            rdata_q <= we_q ? '0 : mem_rdata;
            err_q   <= 1'b0;
          end else if (timed_out) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    last_d <= grant_d;
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign mem_we   = (state == BUSY) &  we_q;
  assign mem_re   = (state == BUSY) & ~we_q;
  assign if_ack   = (state == RESP) & ~grant_d;
  assign d_ack    = (state == RESP) &  grant_d;
  assign if_err   = if_ack & err_q;
  assign d_err    = d_ack & err_q;
  assign if_rdata = rdata_q;
  assign d_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios, a transaction-level
// reference model compared every cycle, and hand-computed literal checks.
module tb_mem_arbiter;

  // Long enough for the 21-cycle store, short enough to exercise the timeout.
  localparam int unsigned TO = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we, d_unsigned, mem_done;
  logic [63:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [1:0]  d_size;
  logic [63:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, if_err, d_ack, d_err, mem_we, mem_re, mem_unsigned, busy;
  logic [1:0]  mem_size;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_unsigned(d_unsigned), .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_rdata(mem_rdata),
    .mem_done(mem_done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Reference model: one outstanding transaction, described by who owns it,
  // what was latched, how long it has waited, and whether it is answering now.
  logic        m_txn = 1'b0, m_resp = 1'b0, m_last_d = 1'b0, m_port = 1'b0;
  logic        m_we = 1'b0, m_uns = 1'b0, m_err = 1'b0;
  logic [63:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic [1:0]  m_size = '0;
  int unsigned m_age = 0;
  logic        m_pick_d;

  assign m_pick_d = d_req && !(if_req && m_last_d);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_txn <= 1'b0; m_resp <= 1'b0; m_last_d <= 1'b0; m_port <= 1'b0;
      m_we <= 1'b0; m_uns <= 1'b0; m_err <= 1'b0; m_age <= 0;
      m_addr <= '0; m_wdata <= '0; m_rdata <= '0; m_size <= '0;
    end else if (m_resp) begin
      m_last_d <= m_port;
      m_resp   <= 1'b0;
      m_txn    <= 1'b0;
    end else if (m_txn) begin
      if (mem_done) begin
        m_rdata <= m_we ? 64'd0 : mem_rdata;
        m_err   <= 1'b0;
        m_resp  <= 1'b1;
      end else if (m_age + 1 == TO) begin
        m_rdata <= 64'd0;
        m_err   <= 1'b1;
        m_resp  <= 1'b1;
      end else begin
        m_age <= m_age + 1;
      end
    end else if (if_req || d_req) begin
      m_txn  <= 1'b1;
      m_age  <= 0;
      m_port <= m_pick_d;
      m_addr <= m_pick_d ? d_addr : if_addr;
      m_wdata <= m_pick_d ? d_wdata : 64'd0;
      m_we   <= m_pick_d ? d_we : 1'b0;
      m_size <= m_pick_d ? d_size : 2'b11;
      m_uns  <= m_pick_d ? d_unsigned : 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("busy",         64'(busy),         64'(m_txn));
    chk("mem_we",       64'(mem_we),       64'(m_txn && !m_resp && m_we));
    chk("mem_re",       64'(mem_re),       64'(m_txn && !m_resp && !m_we));
    chk("mem_addr",     mem_addr,          m_addr);
    chk("mem_wdata",    mem_wdata,         m_wdata);
    chk("mem_size",     64'(mem_size),     64'(m_size));
    chk("mem_unsigned", 64'(mem_unsigned), 64'(m_uns));
    chk("if_ack",       64'(if_ack),       64'(m_resp && !m_port));
    chk("d_ack",        64'(d_ack),        64'(m_resp && m_port));
    chk("if_err",       64'(if_err),       64'(m_resp && !m_port && m_err));
    chk("d_err",        64'(d_err),        64'(m_resp && m_port && m_err));
    chk("if_rdata",     if_rdata,          m_rdata);
    chk("d_rdata",      d_rdata,           m_rdata);
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, we_n, re_n, acks, n;
    bit got;
    int ord_port[4];
    int ord_cyc[4];

    reset = 1'b1;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    d_size = '0; d_unsigned = 0; mem_rdata = '0; mem_done = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_acks", 64'({if_ack, d_ack, mem_we, mem_re}), 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Single fetch, completion in the first BUSY cycle
    @(posedge clk); #1 if_req = 1; if_addr = 64'h100; c0 = cyc;
    @(posedge clk); #1 if_req = 0; mem_done = 1; mem_rdata = 64'hDEADBEEF_CAFEF00D;
    @(negedge clk);
    chk("fetch_re", 64'(mem_re), 64'd1);
    chk("fetch_size", 64'(mem_size), 64'd3);
    @(posedge clk); #1 mem_done = 0; mem_rdata = '0;
    @(negedge clk);
    chk("fetch_ack", 64'(if_ack), 64'd1);
    chk("fetch_latency", 64'(cyc - c0), 64'd2);
    chk("fetch_rdata", if_rdata, 64'hDEADBEEF_CAFEF00D);
    chk("fetch_err", 64'(if_err), 64'd0);
    chk("fetch_dack", 64'(d_ack), 64'd0);
    chk("fetch_re_1cyc", 64'(mem_re), 64'd0);

    // Size and sign passthrough, byte signed load at 0x7
    @(posedge clk); #1 d_req = 1; d_we = 0; d_addr = 64'h7; d_size = 2'b00; d_unsigned = 0;
    @(posedge clk); #1 d_req = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sz_size", 64'(mem_size), 64'd0);
      chk("sz_uns", 64'(mem_unsigned), 64'd0);
      chk("sz_addr", mem_addr, 64'h7);
      @(posedge clk); #1 mem_done = (i == 1); mem_rdata = 64'hFFFF_FFFF_FFFF_FF80;
    end
    @(negedge clk);
    chk("sz_ack", 64'(d_ack), 64'd1);
    chk("sz_rdata", d_rdata, 64'hFFFF_FFFF_FFFF_FF80);

    // Store with completion after 20 waiting cycles
    @(posedge clk); #1 d_req = 1; d_we = 1; d_addr = 64'h2_0008;
    d_wdata = 64'h1122334455667788; d_size = 2'b11; d_unsigned = 0;
    @(posedge clk); #1 d_req = 0; d_we = 0;
    we_n = 0; re_n = 0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      we_n += int'(mem_we);
      re_n += int'(mem_re);
      chk("st_wdata", mem_wdata, 64'h1122334455667788);
      @(posedge clk); #1 mem_done = (i == 19); mem_rdata = 64'hAAAA;
    end
    @(negedge clk);
    chk("st_we_cycles", 64'(we_n), 64'd21);
    chk("st_re_cycles", 64'(re_n), 64'd0);
    chk("st_ack", 64'(d_ack), 64'd1);
    chk("st_rdata_zero", d_rdata, 64'd0);
    @(negedge clk);
    chk("st_ack_pulse", 64'(d_ack), 64'd0);

    // Timeout on a load that never completes
    @(posedge clk); #1 d_req = 1; d_we = 0; d_addr = 64'h40; d_size = 2'b10; d_unsigned = 1; c0 = cyc;
    @(posedge clk); #1 d_req = 0;
    got = 0;
    for (int i = 0; i < int'(TO) + 10 && !got; i++) begin
      @(negedge clk);
      if (d_ack) begin
        got = 1;
        chk("to_latency", 64'(cyc - c0), 64'(TO + 1));
        chk("to_err", 64'(d_err), 64'd1);
        chk("to_rdata", d_rdata, 64'd0);
      end
    end
    chk("to_ack_seen", 64'(got), 64'd1);

    // Fetch after timeout completes normally
    @(posedge clk); #1 if_req = 1; if_addr = 64'h200; c0 = cyc;
    @(posedge clk); #1 if_req = 0; mem_done = 1; mem_rdata = 64'h0123_4567_89AB_CDEF;
    @(posedge clk); #1 mem_done = 0;
    @(negedge clk);
    chk("post_to_ack", 64'(if_ack), 64'd1);
    chk("post_to_err", 64'(if_err), 64'd0);
    chk("post_to_latency", 64'(cyc - c0), 64'd2);
    chk("post_to_rdata", if_rdata, 64'h0123_4567_89AB_CDEF);

    // Reset during the third BUSY cycle of a load
    @(posedge clk); #1 d_req = 1; d_we = 0; d_addr = 64'h80; d_size = 2'b11;
    @(posedge clk); #1 d_req = 0;
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_re", 64'(mem_re), 64'd0);
    chk("mid_rst_addr", mem_addr, 64'd0);
    chk("mid_rst_rdata", d_rdata, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      acks += int'(if_ack) + int'(d_ack);
    end
    chk("mid_rst_no_ack", 64'(acks), 64'd0);

    // Continuous tie after reset: D, IF, D, IF at 3-cycle spacing
    @(posedge clk); #1 if_req = 1; d_req = 1; if_addr = 64'h300; d_addr = 64'h400;
    d_we = 0; d_size = 2'b11; mem_done = 1; mem_rdata = 64'h77; c0 = cyc;
    n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      @(negedge clk);
      if (if_ack || d_ack) begin
        ord_port[n] = int'(d_ack);
        ord_cyc[n]  = cyc;
        n++;
      end
    end
    @(posedge clk); #1 if_req = 0; d_req = 0; mem_done = 0;
    chk("tie_count", 64'(n), 64'd4);
    if (n == 4) begin
      chk("tie_first_cyc", 64'(ord_cyc[0] - c0), 64'd2);
      for (int j = 0; j < 4; j++) begin
        chk("tie_order", 64'(ord_port[j]), 64'((j % 2) == 0));
        if (j > 0) chk("tie_spacing", 64'(ord_cyc[j] - ord_cyc[j-1]), 64'd3);
      end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single core-side port of the memory controller between the instruction-fetch unit and the load/store unit. It sits between the core pipeline and the memory controller. It latches one request at a time and drives the controller's strobes until completion is reported, which covers both SRAM and multi-cycle SPI-backed accesses. It then returns read data with a one-cycle acknowledge, and aborts with an error if completion never arrives.

## Interface
- TIMEOUT, 1024, max cycles in BUSY before the transaction is aborted with error (≥2)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, level; held until if_ack
- if_addr  in  64  fetch address
- if_rdata  out  64  fetch read data, valid while if_ack=1
- if_ack  out  1  one-cycle completion pulse for fetch
- if_err  out  1  timeout flag, valid with if_ack
- d_req  in  1  load/store request, level; held until d_ack
- d_we  in  1  1=store, 0=load
- d_addr  in  64  data address
- d_wdata  in  64  store data
- d_size  in  2  access size (00 B, 01 H, 10 W, 11 D)
- d_unsigned  in  1  zero-extend load
- d_rdata  out  64  load data, valid while d_ack=1
- d_ack  out  1  one-cycle completion pulse for data
- d_err  out  1  timeout flag, valid with d_ack
- mem_addr  out  64  address to controller
- mem_wdata  out  64  write data to controller
- mem_we  out  1  write strobe
- mem_re  out  1  read strobe
- mem_size  out  2  access size to controller
- mem_unsigned  out  1  sign mode to controller
- mem_rdata  in  64  read data from controller
- mem_done  in  1  controller completion, sampled only in BUSY
- busy  out  1  high in BUSY and RESP

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - If any req is high, arbitrate and latch addr, wdata, we, size and unsigned of the winner into mem_* registers, then go to BUSY.
  - A fetch is latched as a read with size=11 and unsigned=1.
- **Arbitration**
  - Round-robin on last_grant (reset value = IF).
  - A single requester always wins.
  - When both request, the port not granted last wins. After reset, data wins the first tie.
- **BUSY**
  - If granted we=1, mem_we=1 and mem_re=0; otherwise mem_re=1 and mem_we=0.
  - mem_* fields stay stable throughout BUSY.
  - On mem_done=1: capture mem_rdata (stores capture 0), clear err, go to RESP.
  - When the cycle counter reaches TIMEOUT-1 without mem_done: capture 0, set err, go to RESP.
- **RESP**
  - Strobes are low.
  - The granted port's ack=1 and its err shows the captured flag. Both rdata outputs show the captured word.
  - Update last_grant, then go to IDLE.
- **Requester rules**
  - A requester must drop req, or present a new request, on the clock edge that ends its ack cycle.
  - A req dropped before ack does not cancel the transaction; ack is still pulsed.
- **Reset (any state, including mid-transaction)**
  - Go to IDLE, last_grant=IF.
  - All outputs 0: strobes, acks, errs, busy, mem_addr, mem_wdata, mem_size, mem_unsigned, rdata.
  - No ack is issued for the aborted transaction.

## Timing
- Request sampled at edge k (IDLE) gives BUSY from k+1, with mem_we or mem_re visible in cycle k+1.
- mem_done seen at edge k+1+n (n≥0) gives RESP and ack high in cycle k+2+n. Minimum req-to-ack latency is 2 cycles.
- Timeout: with no mem_done, ack and err go high in cycle k+1+TIMEOUT.
- Back-to-back transactions: IDLE lasts one cycle, so the next grant occurs at the edge ending the IDLE after RESP. Peak throughput is one transaction per 3 cycles.
- Requests changing while BUSY or RESP have no effect on the latched transaction.
- mem_done outside BUSY is ignored.

## Test plan
- **Single fetch.** if_req=1 with if_addr=0x100; controller returns mem_done one cycle after mem_re with mem_rdata=0xDEADBEEF_CAFEF00D. Required: mem_re high 1 cycle, if_ack in cycle k+2, if_rdata=0xDEADBEEF_CAFEF00D, if_err=0, d_ack=0.
- **Store with slow completion.** d_req=1, d_we=1, d_addr=0x2_0008, d_wdata=0x1122334455667788, d_size=11; mem_done after 20 cycles. Required:
  - mem_we held 21 cycles with mem_wdata stable.
  - d_ack a single pulse.
  - mem_re=0 throughout.
- **Tie after reset.** if_req and d_req both high in the same cycle with continuous requests. Required: grants alternate D, IF, D, IF with 3-cycle spacing; no port is starved.
- **Timeout.** TIMEOUT=8, d_req load, mem_done never asserted. Required: d_ack=1 and d_err=1 in cycle k+9, d_rdata=0, then IDLE; a following fetch completes normally.
- **Reset mid-BUSY.** Assert reset during cycle 3 of a BUSY load, then release. Required: all outputs 0 immediately, no ack, last_grant=IF; a later d_req is granted from IDLE.
- **Size and sign passthrough.** d_size=00, d_unsigned=0, d_addr=0x7. Required: mem_size=00, mem_unsigned=0, mem_addr=0x7 for the whole of BUSY.
